cv32e40p_instr_encoder: RTL and testbench
=========================================

CV32E40P_INSTR_ENCODER -- requirements
Module: cv32e40p_instr_encoder

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the emitted-instruction counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; reset is synchronous and active-low.
REQ-004 SHALL have port req_valid_i, input, 1, field request valid.
REQ-005 SHALL have port req_ready_o, output, 1, encoder can accept a request.
REQ-006 SHALL have port req_class_i, input, 4, class: 0 OP, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 SYSTEM, 10-15 reserved.
REQ-007 SHALL have port req_funct_i, input, 4, [2:0] funct3 / SYSTEM selector, [3] alternate bit (instr[30]).
REQ-008 SHALL have ports req_rd_i, req_rs1_i, req_rs2_i, input, 5 each, register indices.
REQ-009 SHALL have port req_imm_i, input, 32, immediate as a signed byte-offset/value.
REQ-010 SHALL have port flush_i, input, 1, discard all buffered instructions.
REQ-011 SHALL have port instr_valid_o, output, 1, encoded instruction valid.
REQ-012 SHALL have port instr_ready_i, input, 1, consumer (decoder-side bench) accepts instruction.
REQ-013 SHALL have port instr_rdata_o, output, 32, encoded RV32 instruction word.
REQ-014 SHALL have port instr_illegal_o, output, 1, current word came from an unencodable request.
REQ-015 SHALL have port instr_cnt_o, output, CNT_WIDTH, instructions handed off, wraps.
REQ-016 SHALL have port err_cnt_o, output, 8, unencodable requests accepted, saturates at 255.

Function
REQ-017 SHALL hold a 2-entry FIFO of {word, illegal}; req_ready_o = entries<2; transfers occur when valid&&ready on either side.
REQ-018 SHALL register the encoded word on acceptance; into an empty FIFO, instr_valid_o rises the cycle after acceptance (latency 1).
REQ-019 SHALL, with FIFO full and a simultaneous output pop, keep req_ready_o low that cycle (no combinational ready path from instr_ready_i).
REQ-020 SHALL hold instr_rdata_o/instr_illegal_o stable while instr_valid_o=1 and instr_ready_i=0.
REQ-021 SHALL encode OP as opcode 0110011, funct7=0100000 if funct[3] else 0; funct[3] legal only with funct3 000/101.
REQ-022 SHALL encode OP-IMM as 0010011 with I-imm; imm in [-2048,2047]; for funct3 001/101 imm[31:5] must be 0, shamt=imm[4:0], instr[30]=funct[3] (legal only for 101).
REQ-023 SHALL encode LOAD 0000011 (funct3 000,001,010,100,101), JALR 1100111 (funct3 000), I-imm in [-2048,2047].
REQ-024 SHALL encode STORE 0100011 (funct3 000,001,010) with S-imm in [-2048,2047].
REQ-025 SHALL encode BRANCH 1100011 (funct3 not 010/011) with B-imm, even, in [-4096,4094].
REQ-026 SHALL encode LUI 0110111 / AUIPC 0010111 with instr[31:12]=imm[31:12]; imm[11:0] must be 0.
REQ-027 SHALL encode JAL 1101111 with J-imm, even, in [-1048576,1048574].
REQ-028 SHALL encode SYSTEM selector 0..3 as 0x00000073, 0x00100073, 0x30200073, 0x10500073; other selectors unencodable.
REQ-029 SHALL, for reserved classes or any violated range/field rule, emit word 0x00000000 with instr_illegal_o=1 and increment err_cnt_o at acceptance.
REQ-030 SHALL require req_funct_i[3]=0 for all classes other than OP/OP-IMM; otherwise unencodable.
REQ-031 SHALL increment instr_cnt_o on each output handshake, wrapping at 2^CNT_WIDTH.
REQ-032 SHALL, on flush_i, empty the FIFO next cycle, ignore a same-cycle request and output handshake (no count increments), and keep counters.

Reset
REQ-033 SHALL, when rst_n=0 at a clock edge, empty the FIFO, set instr_valid_o=0, instr_rdata_o=0, instr_illegal_o=0, instr_cnt_o=0, err_cnt_o=0, req_ready_o=1 next cycle.
REQ-034 SHALL, on reset mid-transfer, discard buffered entries with no partial output.

Verification
REQ-035 SHALL check: class 0, funct 0, rd=1, rs1=2, rs2=3 -> 0x003100B3 one cycle later, illegal=0.
REQ-036 SHALL check: class 4, funct 1, rs1=5, rs2=6, imm=-4 -> 0xFE629EE3; imm=3 -> 0x00000000, illegal=1, err_cnt_o=1.
REQ-037 SHALL check: instr_ready_i=0, 3 back-to-back requests -> req_ready_o low after 2 accepts, third stalls, words emerge in order once instr_ready_i=1, instr_cnt_o=3.
REQ-038 SHALL check: class 9 funct 2 -> 0x30200073; class 12 -> illegal; 300 illegal requests -> err_cnt_o=255.
REQ-039 SHALL check: FIFO holding 2 entries, flush_i with req_valid_i=1 -> instr_valid_o=0 next cycle, instr_cnt_o unchanged.
REQ-040 SHALL check: rst_n low with 2 entries buffered -> all outputs reset values next cycle, req_ready_o=1.

Source files
------------

// File: rtl/cv32e40p_instr_encoder_if.sv
// Request and instruction channels of the RV32 instruction encoder.
// The slave modport is the encoder side, the master modport is the driver/consumer side.
interface cv32e40p_instr_encoder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_class_i;
    logic [3:0]  req_funct_i;
    logic [4:0]  req_rd_i;
    logic [4:0]  req_rs1_i;
    logic [4:0]  req_rs2_i;
    logic [31:0] req_imm_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_rdata_o;
    logic        instr_illegal_o;

    modport slave (
        input  req_valid_i, req_class_i, req_funct_i, req_rd_i, req_rs1_i, req_rs2_i,
               req_imm_i, instr_ready_i,
        output req_ready_o, instr_valid_o, instr_rdata_o, instr_illegal_o
    );

    modport master (
        output req_valid_i, req_class_i, req_funct_i, req_rd_i, req_rs1_i, req_rs2_i,
               req_imm_i, instr_ready_i,
        input  req_ready_o, instr_valid_o, instr_rdata_o, instr_illegal_o
    );
endinterface

// File: rtl/cv32e40p_instr_encoder.sv
// Encodes field-level instruction requests into RV32I words through a 2-entry FIFO,
// flagging unencodable requests and counting emitted and illegal instructions.
module cv32e40p_instr_encoder #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    cv32e40p_instr_encoder_if.slave bus,
    output logic [CNT_WIDTH-1:0]   instr_cnt_o,
    output logic [7:0]             err_cnt_o
);
    localparam int unsigned DEPTH_W = 2;

    localparam logic [3:0] CLS_OP     = 4'd0;
    localparam logic [3:0] CLS_OPIMM  = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_LUI    = 4'd5;
    localparam logic [3:0] CLS_AUIPC  = 4'd6;
    localparam logic [3:0] CLS_JAL    = 4'd7;
    localparam logic [3:0] CLS_JALR   = 4'd8;
    localparam logic [3:0] CLS_SYSTEM = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic        illegal;
        logic [31:0] word;
    } entry_t;

    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        imm_i_ok, imm_b_ok, imm_j_ok;
    logic [31:0] enc_word_c;
    logic        enc_legal_c;

    assign f3  = bus.req_funct_i[2:0];
    assign alt = bus.req_funct_i[3];
    assign rd  = bus.req_rd_i;
    assign rs1 = bus.req_rs1_i;
    assign rs2 = bus.req_rs2_i;
    assign imm = bus.req_imm_i;

    // Signed range checks: upper bits must be a pure sign extension.
    assign imm_i_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign imm_b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign imm_j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

    always_comb begin
        enc_word_c  = '0;
        enc_legal_c = 1'b0;
        case (bus.req_class_i)
            CLS_OP: begin
                enc_legal_c = ~alt | (f3 == 3'b000) | (f3 == 3'b101);
                enc_word_c  = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, OPC_OP};
            end
            CLS_OPIMM: begin
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    enc_legal_c = ~(|imm[31:5]) & (~alt | (f3 == 3'b101));
                    enc_word_c  = {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, OPC_OPIMM};
                end else begin
                    enc_legal_c = ~alt & imm_i_ok;
                    enc_word_c  = {imm[11:0], rs1, f3, rd, OPC_OPIMM};
                end
            end
            CLS_LOAD: begin
                enc_legal_c = ~alt & imm_i_ok & (f3 != 3'b011) & (f3[2:1] != 2'b11);
                enc_word_c  = {imm[11:0], rs1, f3, rd, OPC_LOAD};
            end
            CLS_STORE: begin
                enc_legal_c = ~alt & imm_i_ok & ~f3[2] & (f3 != 3'b011);
                enc_word_c  = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
            end
            CLS_BRANCH: begin
                enc_legal_c = ~alt & imm_b_ok & (f3[2:1] != 2'b01);
                enc_word_c  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
            end
            CLS_LUI, CLS_AUIPC: begin
                enc_legal_c = ~alt & ~(|imm[11:0]);
                enc_word_c  = {imm[31:12], rd, (bus.req_class_i == CLS_LUI) ? OPC_LUI : OPC_AUIPC};
            end
            CLS_JAL: begin
                enc_legal_c = ~alt & imm_j_ok;
                enc_word_c  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            end
            CLS_JALR: begin
                enc_legal_c = ~alt & imm_i_ok & (f3 == 3'b000);
                enc_word_c  = {imm[11:0], rs1, f3, rd, OPC_JALR};
            end
            CLS_SYSTEM: begin
                // ECALL, EBREAK, MRET, WFI
                enc_legal_c = ~alt & ~f3[2];
                case (f3[1:0])
                    2'd0:    enc_word_c = 32'h0000_0073;
                    2'd1:    enc_word_c = 32'h0010_0073;
                    2'd2:    enc_word_c = 32'h3020_0073;
                    default: enc_word_c = 32'h1050_0073;
                endcase
            end
            default: begin
                enc_legal_c = 1'b0;
                enc_word_c  = '0;
            end
        endcase
        if (!enc_legal_c) begin
            enc_word_c = '0;
        end
    end

    entry_t                 slot0_q, slot0_d, slot1_q, slot1_d, new_entry;
    logic [DEPTH_W-1:0]     count_q, count_d;
    logic                   valid_q, valid_d, ready_q, ready_d;
    logic [CNT_WIDTH-1:0]   instr_cnt_q, instr_cnt_d;
    logic [7:0]             err_cnt_q, err_cnt_d;
    logic                   push, pop;

    assign new_entry = '{illegal: ~enc_legal_c, word: enc_word_c};
    assign push      = bus.req_valid_i & ready_q & ~flush_i;
    assign pop       = valid_q & bus.instr_ready_i & ~flush_i;

    // Shift FIFO: slot0 is always the head, so outputs come straight from registers.
    always_comb begin
        slot0_d     = slot0_q;
        slot1_d     = slot1_q;
        count_d     = count_q;
        instr_cnt_d = instr_cnt_q + CNT_WIDTH'(pop);
        err_cnt_d   = err_cnt_q;
        if (push && !enc_legal_c && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        if (flush_i) begin
            slot0_d = '0;
            slot1_d = '0;
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) slot0_d = new_entry;
                    else                 slot1_d = new_entry;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    slot1_d = '0;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    slot0_d = (count_q == 2'd1) ? new_entry : slot1_q;
                    slot1_d = (count_q == 2'd1) ? entry_t'('0) : new_entry;
                end
                default: ;
            endcase
        end
        valid_d = (count_d != 2'd0);
        ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot0_q     <= '0;
            slot1_q     <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            instr_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            instr_cnt_q <= instr_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.req_ready_o     = ready_q;
    assign bus.instr_valid_o   = valid_q;
    assign bus.instr_rdata_o   = slot0_q.word;
    assign bus.instr_illegal_o = slot0_q.illegal;
    assign instr_cnt_o         = instr_cnt_q;
    assign err_cnt_o           = err_cnt_q;
endmodule

// File: tb/tb_cv32e40p_instr_encoder.sv
// Bench for cv32e40p_instr_encoder: directed scenarios plus randomized traffic
// checked against an arithmetic encoding model and a queue-based FIFO model.
module tb_cv32e40p_instr_encoder;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic [15:0] instr_cnt;
    logic [7:0]  err_cnt;

    cv32e40p_instr_encoder_if bus();

    cv32e40p_instr_encoder #(.CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .bus         (bus),
        .instr_cnt_o (instr_cnt),
        .err_cnt_o   (err_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [32:0] exp_q[$];
    int m_icnt = 0;
    int m_ecnt = 0;

    // Reference encoding from the field-placement rules; returns {illegal, word}.
    function automatic logic [32:0] model_encode(input logic [3:0] cls, input logic [3:0] fn,
                                                 input logic [4:0] rd, input logic [4:0] rs1,
                                                 input logic [4:0] rs2, input logic [31:0] imm);
        int s; bit ok; bit alt;
        logic [31:0] w, f3, rdf, rs1f, rs2f, f3f;
        s = $signed(imm);
        f3 = 32'(fn[2:0]); alt = fn[3];
        rdf = 32'(rd) << 7; rs1f = 32'(rs1) << 15; rs2f = 32'(rs2) << 20; f3f = f3 << 12;
        ok = 0; w = 0;
        case (cls)
            4'd0: begin
                ok = !alt || f3 == 0 || f3 == 5;
                w = (alt ? 32'h4000_0000 : 32'h0) | rs2f | rs1f | f3f | rdf | 32'h33;
            end
            4'd1: begin
                if (f3 == 1 || f3 == 5) begin
                    ok = (imm < 32) && (!alt || f3 == 5);
                    w = (alt ? 32'h4000_0000 : 32'h0) | ((imm & 32'h1f) << 20) | rs1f | f3f | rdf | 32'h13;
                end else begin
                    ok = !alt && s >= -2048 && s <= 2047;
                    w = ((imm & 32'hfff) << 20) | rs1f | f3f | rdf | 32'h13;
                end
            end
            4'd2: begin
                ok = !alt && (f3 inside {0, 1, 2, 4, 5}) && s >= -2048 && s <= 2047;
                w = ((imm & 32'hfff) << 20) | rs1f | f3f | rdf | 32'h03;
            end
            4'd3: begin
                ok = !alt && f3 <= 2 && s >= -2048 && s <= 2047;
                w = (((imm >> 5) & 32'h7f) << 25) | rs2f | rs1f | f3f | ((imm & 32'h1f) << 7) | 32'h23;
            end
            4'd4: begin
                ok = !alt && f3 != 2 && f3 != 3 && (s % 2) == 0 && s >= -4096 && s <= 4094;
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | rs2f | rs1f | f3f
                    | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
            end
            4'd5, 4'd6: begin
                ok = !alt && (imm & 32'hfff) == 0;
                w = imm | rdf | ((cls == 4'd5) ? 32'h37 : 32'h17);
            end
            4'd7: begin
                ok = !alt && (s % 2) == 0 && s >= -1048576 && s <= 1048574;
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21) | (((imm >> 11) & 1) << 20)
                    | (((imm >> 12) & 32'hff) << 12) | rdf | 32'h6f;
            end
            4'd8: begin
                ok = !alt && f3 == 0 && s >= -2048 && s <= 2047;
                w = ((imm & 32'hfff) << 20) | rs1f | f3f | rdf | 32'h67;
            end
            4'd9: begin
                ok = !alt && f3 < 4;
                case (f3)
                    0: w = 32'h0000_0073;
                    1: w = 32'h0010_0073;
                    2: w = 32'h3020_0073;
                    default: w = 32'h1050_0073;
                endcase
            end
            default: ok = 0;
        endcase
        if (!ok) w = 0;
        return {!ok, w};
    endfunction

    // Advance one clock, applying the handshakes the queue model predicts.
    task automatic tick(output bit acc, output bit popped);
        bit m_rdy, m_vld;
        logic [32:0] e;
        m_rdy = exp_q.size() < 2;
        m_vld = exp_q.size() > 0;
        acc = 0; popped = 0;
        if (!rst_n) begin
            exp_q.delete(); m_icnt = 0; m_ecnt = 0;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            if (m_vld && bus.instr_ready_i) begin
                void'(exp_q.pop_front()); m_icnt++; popped = 1;
            end
            if (bus.req_valid_i && m_rdy) begin
                e = model_encode(bus.req_class_i, bus.req_funct_i, bus.req_rd_i, bus.req_rs1_i,
                                 bus.req_rs2_i, bus.req_imm_i);
                exp_q.push_back(e);
                if (e[32] && m_ecnt < 255) m_ecnt++;
                acc = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_req(input logic [3:0] cls, input logic [3:0] fn, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        bus.req_class_i = cls; bus.req_funct_i = fn; bus.req_rd_i = rd;
        bus.req_rs1_i = rs1; bus.req_rs2_i = rs2; bus.req_imm_i = imm;
    endtask

    task automatic rand_req();
        logic [31:0] imm;
        case ($urandom_range(0, 3))
            0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1: imm = $urandom;
            2: imm = $urandom & 32'hFFFF_F000;
            default: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
        endcase
        set_req(($urandom_range(0, 7) == 0) ? 4'(10 + $urandom_range(0, 5)) : 4'($urandom_range(0, 9)),
                {1'($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7))},
                5'($urandom), 5'($urandom), 5'($urandom), imm);
    endtask

    // Offer the current request for one cycle with the consumer stalled (FIFO has room).
    task automatic send_one();
        bit a, p;
        bus.instr_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        tick(a, p);
        bus.req_valid_i = 1'b0;
    endtask

    task automatic drain();
        bit a, p;
        bus.req_valid_i = 1'b0;
        bus.instr_ready_i = 1'b1;
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) tick(a, p);
        bus.instr_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        bit a, p;
        rst_n = 1'b0;
        tick(a, p); tick(a, p);
        rst_n = 1'b1;
        tests++; if (bus.req_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.req_ready_o); end
        tests++; if (bus.instr_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.instr_valid_o); end
        tests++; if (bus.instr_rdata_o !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", bus.instr_rdata_o); end
        tests++; if (bus.instr_illegal_o !== 1'b0) begin fails++; $display("FAIL reset_illegal got %b want 0", bus.instr_illegal_o); end
        tests++; if (instr_cnt !== 16'h0 || err_cnt !== 8'h0) begin fails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", instr_cnt, err_cnt); end
    endtask

    task automatic test_op_basic();
        set_req(4'd0, 4'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        tests++; if (bus.instr_valid_o !== 1'b0) begin fails++; $display("FAIL op_pre_valid got %b want 0", bus.instr_valid_o); end
        send_one();
        tests++; if (bus.instr_valid_o !== 1'b1) begin fails++; $display("FAIL op_latency got valid=%b want 1", bus.instr_valid_o); end
        tests++; if (bus.instr_rdata_o !== 32'h003100B3 || bus.instr_illegal_o !== 1'b0) begin
            fails++; $display("FAIL op_word got %h/%b want 003100b3/0", bus.instr_rdata_o, bus.instr_illegal_o); end
        drain();
        tests++; if (bus.instr_valid_o !== 1'b0 || instr_cnt !== 16'(m_icnt)) begin
            fails++; $display("FAIL op_drain got valid=%b cnt=%0d want 0/%0d", bus.instr_valid_o, instr_cnt, m_icnt); end
    endtask

    task automatic test_branch();
        set_req(4'd4, 4'd1, 5'd0, 5'd5, 5'd6, -32'sd4);
        send_one();
        tests++; if (bus.instr_rdata_o !== 32'hFE629EE3 || bus.instr_illegal_o !== 1'b0) begin
            fails++; $display("FAIL branch_neg4 got %h/%b want fe629ee3/0", bus.instr_rdata_o, bus.instr_illegal_o); end
        drain();
        set_req(4'd4, 4'd1, 5'd0, 5'd5, 5'd6, 32'd3);
        send_one();
        tests++; if (bus.instr_rdata_o !== 32'h0 || bus.instr_illegal_o !== 1'b1) begin
            fails++; $display("FAIL branch_odd got %h/%b want 0/1", bus.instr_rdata_o, bus.instr_illegal_o); end
        tests++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL branch_errcnt got %0d want 1", err_cnt); end
        drain();
    endtask

    task automatic test_back_to_back();
        bit a, p;
        int sent, popped_n, base;
        base = m_icnt; sent = 0; popped_n = 0;
        bus.instr_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        set_req(4'd0, 4'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick(a, p);
            if (a) begin sent++; set_req(4'd0, 4'd0, 5'(sent + 1), 5'd2, 5'd3, 32'd0); end
            if (c == 0) begin
                tests++; if (bus.req_ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready1 got %b want 1", bus.req_ready_o); end
            end else begin
                tests++; if (bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL b2b_full_c%0d got ready=%b want 0", c, bus.req_ready_o); end
            end
        end
        tests++; if (bus.instr_rdata_o !== 32'h003100B3) begin
            fails++; $display("FAIL b2b_hold got %h want 003100b3", bus.instr_rdata_o); end
        bus.instr_ready_i = 1'b1;
        for (int c = 0; c < 20 && popped_n < 3; c++) begin
            if (exp_q.size() > 0) begin
                tests++; if ({bus.instr_illegal_o, bus.instr_rdata_o} !== exp_q[0] || bus.instr_valid_o !== 1'b1) begin
                    fails++; $display("FAIL b2b_order got %b/%h want %h", bus.instr_valid_o, bus.instr_rdata_o, exp_q[0]); end
            end
            tick(a, p);
            if (p) popped_n++;
            if (a) begin sent++; bus.req_valid_i = 1'b0; end
        end
        bus.instr_ready_i = 1'b0;
        tests++; if (instr_cnt !== 16'(base + 3)) begin fails++; $display("FAIL b2b_cnt got %0d want %0d", instr_cnt, base + 3); end
    endtask

    task automatic test_system_err();
        bit a, p;
        int n;
        set_req(4'd9, 4'd2, 5'd0, 5'd0, 5'd0, 32'd0);
        send_one();
        tests++; if (bus.instr_rdata_o !== 32'h30200073 || bus.instr_illegal_o !== 1'b0) begin
            fails++; $display("FAIL sys_mret got %h/%b want 30200073/0", bus.instr_rdata_o, bus.instr_illegal_o); end
        drain();
        set_req(4'd12, 4'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        send_one();
        tests++; if (bus.instr_illegal_o !== 1'b1 || bus.instr_rdata_o !== 32'h0) begin
            fails++; $display("FAIL reserved_cls got %h/%b want 0/1", bus.instr_rdata_o, bus.instr_illegal_o); end
        n = 0;
        bus.instr_ready_i = 1'b1;
        bus.req_valid_i = 1'b1;
        for (int c = 0; c < 700 && n < 300; c++) begin
            tick(a, p);
            if (a) n++;
        end
        tests++; if (n != 300) begin fails++; $display("FAIL err_stream got %0d accepted want 300", n); end
        drain();
        tests++; if (err_cnt !== 8'd255 || err_cnt !== 8'(m_ecnt)) begin
            fails++; $display("FAIL err_sat got %0d want 255", err_cnt); end
    endtask

    task automatic test_flush();
        bit a, p;
        int icnt_before, ecnt_before;
        rand_req(); send_one();
        rand_req(); send_one();
        tests++; if (bus.req_ready_o !== 1'b0) begin fails++; $display("FAIL flush_fill got ready=%b want 0", bus.req_ready_o); end
        icnt_before = m_icnt; ecnt_before = m_ecnt;
        set_req(4'd12, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        flush = 1'b1; bus.req_valid_i = 1'b1; bus.instr_ready_i = 1'b1;
        tick(a, p);
        flush = 1'b0; bus.req_valid_i = 1'b0; bus.instr_ready_i = 1'b0;
        tests++; if (bus.instr_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            fails++; $display("FAIL flush_empty got valid=%b ready=%b want 0/1", bus.instr_valid_o, bus.req_ready_o); end
        tests++; if (instr_cnt !== 16'(icnt_before) || err_cnt !== 8'(ecnt_before)) begin
            fails++; $display("FAIL flush_cnt got %0d/%0d want %0d/%0d", instr_cnt, err_cnt, icnt_before, ecnt_before); end
    endtask

    task automatic test_random();
        bit a, p;
        for (int c = 0; c < 1500; c++) begin
            tests++; if (bus.req_ready_o !== (exp_q.size() < 2) || bus.instr_valid_o !== (exp_q.size() > 0)) begin
                fails++; $display("FAIL rand_hs c%0d got ready=%b valid=%b model size %0d", c, bus.req_ready_o, bus.instr_valid_o, exp_q.size()); end
            if (exp_q.size() > 0) begin
                tests++; if ({bus.instr_illegal_o, bus.instr_rdata_o} !== exp_q[0]) begin
                    fails++; $display("FAIL rand_word c%0d got %b/%h want %h cls=%0d", c, bus.instr_illegal_o, bus.instr_rdata_o, exp_q[0], bus.req_class_i); end
            end
            if (a || !bus.req_valid_i) rand_req();
            bus.req_valid_i = 1'($urandom_range(0, 3) != 0);
            bus.instr_ready_i = 1'($urandom_range(0, 2) != 0);
            flush = 1'($urandom_range(0, 39) == 0);
            tick(a, p);
        end
        flush = 1'b0;
        drain();
        tests++; if (instr_cnt !== 16'(m_icnt) || err_cnt !== 8'(m_ecnt)) begin
            fails++; $display("FAIL rand_cnt got %0d/%0d want %0d/%0d", instr_cnt, err_cnt, m_icnt, m_ecnt); end
    endtask

    task automatic test_reset_mid();
        bit a, p;
        rand_req(); send_one();
        rand_req(); send_one();
        rst_n = 1'b0; bus.req_valid_i = 1'b1; bus.instr_ready_i = 1'b1;
        tick(a, p);
        rst_n = 1'b1; bus.req_valid_i = 1'b0; bus.instr_ready_i = 1'b0;
        tests++; if (bus.instr_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            fails++; $display("FAIL rstmid_hs got valid=%b ready=%b want 0/1", bus.instr_valid_o, bus.req_ready_o); end
        tests++; if (bus.instr_rdata_o !== 32'h0 || bus.instr_illegal_o !== 1'b0) begin
            fails++; $display("FAIL rstmid_data got %h/%b want 0/0", bus.instr_rdata_o, bus.instr_illegal_o); end
        tests++; if (instr_cnt !== 16'h0 || err_cnt !== 8'h0) begin
            fails++; $display("FAIL rstmid_cnt got %0d/%0d want 0/0", instr_cnt, err_cnt); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        bus.req_valid_i = 1'b0; bus.instr_ready_i = 1'b0;
        set_req(4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        @(negedge clk);
        test_reset();
        test_op_basic();
        test_branch();
        test_back_to_back();
        test_system_err();
        test_flush();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
